seq_alu: RTL
============

Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the combinational 8-bit ALU units (And/Or/Add/Mov). Operands are latched on a start handshake and the operation executes sequentially. Single-cycle ops complete in one clock. Multiply uses shift-add over WIDTH clocks; shifts move one bit per clock. The block sits beside the register file in the processor datapath and the control unit stalls on busy.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2, power of two).
SHW, $clog2(WIDTH), derived localparam: shift-amount width, not overridable.

Ports:
CLK  input  1  clock; all state changes on rising edge
RESET  input  1  synchronous, active-high reset
start  input  1  request; sampled only when not busy
select  input  3  opcode: 000 MOV, 001 ADD, 010 AND, 011 OR, 100 MUL, 101 SLL, 110 SRL, 111 SRA
data1  input  WIDTH  operand 1 (signed)
data2  input  WIDTH  operand 2 (signed); for shifts, data2[SHW-1:0] = amount
result  output  WIDTH  registered result, held until next completion
zero  output  1  registered; 1 when result == 0, updated with result
busy  output  1  high while an accepted op has not yet completed
done  output  1  one-cycle pulse in the cycle result becomes valid

Behaviour:
- Reset (synchronous, active-high): state=IDLE; result=0, zero=1, busy=0, done=0. Aborts any op in progress mid-run; no partial result is written.
- States: IDLE, RUN, DONE. Reset value is IDLE.
- IDLE or DONE with start=1:
  - Latch select, data1, data2. Further input changes are ignored until completion.
  - MOV, ADD, AND, OR, and shifts with amount 0: go to DONE next edge.
  - result = op(data1, data2). Latency is 1: done is high in the cycle after start.
  - MOV: result = data2. ADD: two's complement, WIDTH bits, carry/overflow discarded. AND/OR: bitwise.
  - MUL, or shift with amount != 0: go to RUN and set busy=1 on the same edge.
- RUN, MUL: one shift-add step per clock over WIDTH clocks, using latched data1 × data2.
  - result = low WIDTH bits of the signed product. The low bits are identical for signed and unsigned operands.
  - Enter DONE on edge WIDTH+1 after start; done is high in that cycle.
- RUN, shift: one bit per clock; a counter loaded with the amount decrements to 0.
  - SLL fills with 0. SRL fills with 0. SRA fills with the sign bit.
  - Latency is amount+1 edges.
- DONE: done=1 and busy=0 for exactly one cycle; result and zero are valid.
  - With start=0: next state IDLE.
  - With start=1: the new op is accepted, allowing back-to-back operation. done deasserts unless the new op is also 1-cycle, in which case done stays high one more cycle with the new result.
- start while busy=1: ignored; not queued.
- result and zero change only on the completion edge; intermediate partial values are never visible on result.
- No reserved opcodes.

Test Plan:
- WIDTH=8: RESET 2 cycles -> result=0, zero=1, busy=0, done=0. Then start, AND, data1=25, data2=3 -> after 1 edge done=1, result=00000001, zero=0.
- ADD data1=2, data2=-5 -> result=11111101 (-3) at latency 1. Then ADD 1 + -1 -> result=0, zero=1.
- MUL data1=6, data2=-2 -> busy high for 8 cycles, done on edge 9, result=11110100 (-12). Pulse start=1 with data1=99 during RUN -> ignored, result still -12.
- SRA data1=-8, data2=2 -> done on edge 3, result=11111110. Then SRL same operands -> 00111110. Then SLL data1=1, data2=7 -> 10000000 on edge 8.
- Back-to-back: MOV 5, start held high into DONE with OR 8|1 -> done high two consecutive cycles, results 5 then 9.
- RESET asserted at cycle 4 of MUL -> next edge state IDLE, busy=0, done=0, result=0. Rerun with WIDTH=16: MUL 300×-3 -> result=-900 (0xFC7C) on edge 17.

Source files
------------

// File: rtl/seq_alu.sv
// Multi-cycle ALU: operands latched on start, single-cycle logic/add ops,
// shift-add multiply over WIDTH clocks and one-bit-per-clock shifts.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [2:0]       op;
  logic [WIDTH-1:0] work, mplier, acc;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   amt;
  logic             accept, single, last;
  logic [WIDTH-1:0] alu_out, acc_next, shift_next, run_out;

  assign amt    = data2[SHW-1:0];
  assign accept = start && (state != RUN);
  assign single = (select != OP_MUL) && !(select[2] && (amt != '0));
  assign last   = (cnt == '0);

  always_comb begin
    alu_out = data1;
    case (select)
      OP_MOV:  alu_out = data2;
      OP_ADD:  alu_out = data1 + data2;
      OP_AND:  alu_out = data1 & data2;
      OP_OR:   alu_out = data1 | data2;
      default: alu_out = data1;
    endcase
  end

  // work holds the shifting multiplicand for MUL, or the value being shifted
  always_comb begin
    acc_next = acc + (mplier[0] ? work : '0);
    case (op)
      OP_SLL:  shift_next = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_next = {1'b0, work[WIDTH-1:1]};
      default: shift_next = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
    run_out = (op == OP_MUL) ? acc_next : shift_next;
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_next = single ? DONE : RUN;
        else        state_next = IDLE;
      end
      RUN:     state_next = last ? DONE : RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // result/zero are written only on the completion edge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      result <= '0;
      zero   <= 1'b1;
      op     <= OP_MOV;
      work   <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept) begin
      op     <= select;
      work   <= data1;
      mplier <= data2;
      acc    <= '0;
      cnt    <= (select == OP_MUL) ? SHW'(WIDTH - 1) : amt - SHW'(1);
      if (single) begin
        result <= alu_out;
        zero   <= (alu_out == '0);
      end
    end else if (state == RUN) begin
      work   <= (op == OP_MUL) ? (work << 1) : shift_next;
      mplier <= mplier >> 1;
      acc    <= acc_next;
      cnt    <= cnt - SHW'(1);
      if (last) begin
        result <= run_out;
        zero   <= (run_out == '0);
      end
    end
  end

endmodule
